// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle for the round-robin FIFO write arbiter.
// master = arbiter side, slave = producers plus FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       req;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [WIDTH-1:0] din3;
  logic             fifo_full;
  logic [3:0]       gnt;
  logic [3:0]       ack;
  logic [1:0]       owner;
  logic             busy;
  logic             fifo_wr_en;
  logic [WIDTH-1:0] fifo_din;

  modport master (
    input  req, din0, din1, din2, din3, fifo_full,
    output gnt, ack, owner, busy, fifo_wr_en, fifo_din
  );

  modport slave (
    output req, din0, din1, din2, din3, fifo_full,
    input  gnt, ack, owner, busy, fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between four producers,
// granting bounded bursts and stalling on FIFO full so no word is lost.
module fifo_wr_arbiter #(
  parameter int BURST = 4,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [2:0] BCNT_LAST = 3'(BURST - 1);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [3:0] gnt_q, gnt_d;

  logic             acc;
  logic [1:0]       sel;
  logic             sel_vld;
  logic [WIDTH-1:0] din_sel;

  // Rotating priority: the producer after the last owner is searched first.
  always_comb begin
    sel     = 2'd0;
    sel_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!sel_vld && bus.req[last_q + 2'(k)]) begin
        sel     = last_q + 2'(k);
        sel_vld = 1'b1;
      end
    end
  end

  // rst gates the accept so nothing is written during a reset cycle.
  assign acc = (state_q == GRANT) && bus.req[owner_q] && !bus.fifo_full && !rst;

  always_comb begin
    din_sel = '0;
    case (owner_q)
      2'd0: din_sel = bus.din0;
      2'd1: din_sel = bus.din1;
      2'd2: din_sel = bus.din2;
      2'd3: din_sel = bus.din3;
      default: din_sel = '0;
    endcase
  end

  assign bus.fifo_wr_en = acc;
  assign bus.ack        = acc ? (4'b0001 << owner_q) : 4'b0000;
  assign bus.fifo_din   = ((state_q == GRANT) && !rst) ? din_sel : '0;
  assign bus.gnt        = gnt_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = (state_q == GRANT);

  // NOTE: every _d gets its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          owner_d = sel;
          gnt_d   = 4'b0001 << sel;
          bcnt_d  = 3'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[owner_q] || (acc && (bcnt_q == BCNT_LAST))) begin
          last_d  = owner_q;
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end else if (acc) begin
          bcnt_d = bcnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      bcnt_q  <= 3'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule
